// File: rtl/ddr4_v2_2_20_w_downsizer.sv
// ddr4_v2_2_20_w_downsizer: splits each wide AXI W beat into RATIO narrow beats, steered by a burst command
module ddr4_v2_2_20_w_downsizer #(
    parameter string C_FAMILY           = "virtex6",
    parameter int    C_S_AXI_DATA_WIDTH = 128,
    parameter int    C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                                                   ACLK,
    input  logic                                                   ARESET,
    input  logic                                                   cmd_valid,
    input  logic [$clog2(C_S_AXI_DATA_WIDTH/C_M_AXI_DATA_WIDTH)-1:0] cmd_offset,
    input  logic [7:0]                                             cmd_len,
    output logic                                                   cmd_ready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                        S_AXI_WSTRB,
    input  logic                                                   S_AXI_WLAST,
    input  logic                                                   S_AXI_WVALID,
    output logic                                                   S_AXI_WREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]                          M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]                        M_AXI_WSTRB,
    output logic                                                   M_AXI_WLAST,
    output logic                                                   M_AXI_WVALID,
    input  logic                                                   M_AXI_WREADY
);
    localparam int M     = C_M_AXI_DATA_WIDTH;
    localparam int RATIO = C_S_AXI_DATA_WIDTH / M;
    localparam int IW    = $clog2(RATIO);
    localparam string unused_family = C_FAMILY;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   word_idx;
    logic [7:0]      beat_cnt;
    logic            active, last, m_hs, take_cmd;
    logic [M-1:0]    data_w [RATIO];
    logic [M/8-1:0]  strb_w [RATIO];
    logic            unused_wlast;

    for (genvar g = 0; g < RATIO; g++) begin : g_slice
        assign data_w[g] = S_AXI_WDATA[g*M +: M];
        assign strb_w[g] = S_AXI_WSTRB[g*(M/8) +: M/8];
    end

    assign unused_wlast = S_AXI_WLAST;
    assign active       = (state == ACTIVE);
    assign last         = (beat_cnt == 8'd0);
    assign take_cmd     = !active && cmd_valid;
    assign m_hs         = M_AXI_WVALID && M_AXI_WREADY;
    assign cmd_ready    = !active;
    assign M_AXI_WVALID = active && S_AXI_WVALID;
    assign M_AXI_WLAST  = active && last;
    assign M_AXI_WDATA  = data_w[word_idx];
    assign M_AXI_WSTRB  = strb_w[word_idx];
    // wide beat is released only on its final slice or on the burst's last narrow beat
    assign S_AXI_WREADY = active && M_AXI_WREADY && (word_idx == IW'(RATIO - 1) || last);

    always_comb begin
        state_nxt = take_cmd ? ACTIVE : (m_hs && last) ? IDLE : state;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state    <= IDLE;
            word_idx <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (take_cmd) begin
                word_idx <= cmd_offset;
                beat_cnt <= cmd_len;
            end else if (m_hs) begin
                word_idx <= word_idx + IW'(1);
                beat_cnt <= last ? beat_cnt : beat_cnt - 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_ddr4_v2_2_20_w_downsizer.sv
// tb_ddr4_v2_2_20_w_downsizer: directed checks of the W downsizer with RATIO=4 (128 -> 32 bits)
module tb_ddr4_v2_2_20_w_downsizer;
    logic         ACLK = 1'b0;
    logic         ARESET = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [1:0]   cmd_offset = '0;
    logic [7:0]   cmd_len = '0;
    logic         cmd_ready;
    logic [127:0] S_AXI_WDATA = '0;
    logic [15:0]  S_AXI_WSTRB = '0;
    logic         S_AXI_WLAST = 1'b0;
    logic         S_AXI_WVALID = 1'b0;
    logic         S_AXI_WREADY;
    logic [31:0]  M_AXI_WDATA;
    logic [3:0]   M_AXI_WSTRB;
    logic         M_AXI_WLAST;
    logic         M_AXI_WVALID;
    logic         M_AXI_WREADY = 1'b0;
    int           tests = 0;
    int           fails = 0;

    ddr4_v2_2_20_w_downsizer #(
        .C_FAMILY("virtex6"), .C_S_AXI_DATA_WIDTH(128), .C_M_AXI_DATA_WIDTH(32)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_offset(cmd_offset), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY)
    );

    always #5 ACLK = ~ACLK;

    // wide beat n carries global narrow word g = 4n+k in slice k
    function automatic logic [127:0] wdat(input int n);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[k*32 +: 32] = 32'hD000_0000 + 32'(n*4 + k);
        return r;
    endfunction

    function automatic logic [15:0] wstr(input int n);
        logic [15:0] r;
        for (int k = 0; k < 4; k++) r[k*4 +: 4] = 4'(n*4 + k + 1);
        return r;
    endfunction

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        S_AXI_WVALID = 1'b1;
        M_AXI_WREADY = 1'b1;
        step();
        step();
        #4;
        tests++;
        if ({cmd_ready, M_AXI_WVALID, S_AXI_WREADY, M_AXI_WLAST} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 1000", {cmd_ready, M_AXI_WVALID, S_AXI_WREADY, M_AXI_WLAST});
        end
        step();
        ARESET = 1'b0;
        S_AXI_WVALID = 1'b0;
        step();
    endtask

    task automatic test_burst(input int off, input int len, input bit stall);
        int i = 0, wb = 0, shs = 0, cycles = 0, g;
        bit mr, s_rdy, prev_stall = 0;
        logic [31:0] prev_data = '0;
        logic [3:0]  prev_strb = '0;
        cmd_valid = 1'b1;
        cmd_offset = 2'(off);
        cmd_len = 8'(len);
        #4;
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL burst_cmd_ready: got %b want 1", cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
        S_AXI_WVALID = 1'b1;
        S_AXI_WDATA = wdat(0);
        S_AXI_WSTRB = wstr(0);
        while (i <= len && cycles < 2000) begin
            mr = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            M_AXI_WREADY = mr;
            g = off + i;
            #4;
            tests++;
            if (M_AXI_WVALID !== 1'b1 || M_AXI_WDATA !== 32'hD000_0000 + 32'(g) || M_AXI_WSTRB !== 4'(g + 1)
                || M_AXI_WLAST !== (i == len) || S_AXI_WREADY !== (mr && (g % 4 == 3 || i == len))) begin
                fails++;
                $display("FAIL burst_beat off=%0d len=%0d i=%0d: got v=%b d=%h s=%h l=%b sr=%b want v=1 d=%h s=%h l=%b sr=%b",
                         off, len, i, M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, S_AXI_WREADY,
                         32'hD000_0000 + 32'(g), 4'(g + 1), (i == len), (mr && (g % 4 == 3 || i == len)));
            end
            if (prev_stall) begin
                tests++;
                if (M_AXI_WDATA !== prev_data || M_AXI_WSTRB !== prev_strb) begin
                    fails++;
                    $display("FAIL stall_stable i=%0d: got %h/%h want %h/%h", i, M_AXI_WDATA, M_AXI_WSTRB, prev_data, prev_strb);
                end
            end
            prev_stall = !mr;
            prev_data = M_AXI_WDATA;
            prev_strb = M_AXI_WSTRB;
            s_rdy = S_AXI_WREADY;
            step();
            cycles++;
            if (mr) i++;
            if (s_rdy) begin
                wb++;
                shs++;
                S_AXI_WDATA = wdat(wb);
                S_AXI_WSTRB = wstr(wb);
            end
        end
        S_AXI_WVALID = 1'b0;
        M_AXI_WREADY = 1'b1;
        #4;
        tests++;
        if (cycles >= 2000 || shs != (off + len) / 4 + 1) begin
            fails++;
            $display("FAIL burst_s_handshakes off=%0d len=%0d: got %0d want %0d", off, len, shs, (off + len) / 4 + 1);
        end
        tests++;
        if (cmd_ready !== 1'b1 || M_AXI_WVALID !== 1'b0) begin
            fails++;
            $display("FAIL burst_idle_after: got cmd_ready=%b wvalid=%b want 1 0", cmd_ready, M_AXI_WVALID);
        end
        step();
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1;
        cmd_offset = 2'd0;
        cmd_len = 8'd3;
        S_AXI_WVALID = 1'b1;
        S_AXI_WDATA = wdat(0);
        S_AXI_WSTRB = 16'h8421;
        M_AXI_WREADY = 1'b1;
        #4;
        tests++;
        if ({cmd_ready, M_AXI_WVALID, S_AXI_WREADY} !== 3'b100) begin
            fails++;
            $display("FAIL b2b_first_idle: got %b want 100", {cmd_ready, M_AXI_WVALID, S_AXI_WREADY});
        end
        step();
        cmd_offset = 2'd2;
        cmd_len = 8'd1;
        for (int j = 0; j < 4; j++) begin
            #4;
            tests++;
            if ({cmd_ready, M_AXI_WVALID, M_AXI_WSTRB, M_AXI_WLAST, S_AXI_WREADY} !== {2'b01, 4'(1 << j), j == 3, j == 3}) begin
                fails++;
                $display("FAIL b2b_a_beat%0d: got %b want %b", j, {cmd_ready, M_AXI_WVALID, M_AXI_WSTRB, M_AXI_WLAST, S_AXI_WREADY},
                         {2'b01, 4'(1 << j), j == 3, j == 3});
            end
            step();
        end
        S_AXI_WSTRB = 16'h1248;
        #4;
        tests++;
        if ({cmd_ready, M_AXI_WVALID, S_AXI_WREADY} !== 3'b100) begin
            fails++;
            $display("FAIL b2b_gap_idle: got %b want 100", {cmd_ready, M_AXI_WVALID, S_AXI_WREADY});
        end
        step();
        cmd_valid = 1'b0;
        #4;
        tests++;
        if ({cmd_ready, M_AXI_WVALID, M_AXI_WSTRB, M_AXI_WLAST, S_AXI_WREADY} !== 8'b01_0010_00) begin
            fails++;
            $display("FAIL b2b_b_beat0: got %b want 01001000", {cmd_ready, M_AXI_WVALID, M_AXI_WSTRB, M_AXI_WLAST, S_AXI_WREADY});
        end
        step();
        #4;
        tests++;
        if ({cmd_ready, M_AXI_WVALID, M_AXI_WSTRB, M_AXI_WLAST, S_AXI_WREADY} !== 8'b01_0001_11) begin
            fails++;
            $display("FAIL b2b_b_beat1: got %b want 01000111", {cmd_ready, M_AXI_WVALID, M_AXI_WSTRB, M_AXI_WLAST, S_AXI_WREADY});
        end
        step();
        S_AXI_WVALID = 1'b0;
        #4;
        tests++;
        if (cmd_ready !== 1'b1 || M_AXI_WVALID !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end_idle: got cmd_ready=%b wvalid=%b want 1 0", cmd_ready, M_AXI_WVALID);
        end
        step();
    endtask

    task automatic test_reset_mid_burst();
        cmd_valid = 1'b1;
        cmd_offset = 2'd0;
        cmd_len = 8'd7;
        step();
        cmd_valid = 1'b0;
        S_AXI_WVALID = 1'b1;
        S_AXI_WDATA = wdat(0);
        S_AXI_WSTRB = wstr(0);
        M_AXI_WREADY = 1'b1;
        step();
        step();
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        #4;
        tests++;
        if ({M_AXI_WVALID, cmd_ready, M_AXI_WLAST, S_AXI_WREADY} !== 4'b0100) begin
            fails++;
            $display("FAIL reset_mid_burst: got %b want 0100", {M_AXI_WVALID, cmd_ready, M_AXI_WLAST, S_AXI_WREADY});
        end
        S_AXI_WVALID = 1'b0;
        step();
        test_burst(0, 3, 1'b0);
    endtask

    initial begin
        test_reset();
        test_burst(0, 7, 1'b0);
        test_burst(2, 3, 1'b0);
        test_burst(1, 0, 1'b0);
        test_burst(0, 15, 1'b1);
        test_burst(3, 8, 1'b1);
        test_back_to_back();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
